// File: rtl/instruction_fetch.sv
// Instruction fetch: issues word fetches, buffers returned words with their PCs,
// and streams them in order to decode; redirects flush all in-flight work.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rstf,
  output logic [31:0] imem_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] i_instr,
  output logic        i_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] oPC
);
  localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW      = AW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] pcq_wr;
  logic [AW-1:0] pcq_rd;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   pcq        [DEPTH];

  logic [CW:0]   in_use;
  logic          issue;
  logic          rsp_keep;
  logic          rsp_drop;
  logic          pop;

  // Credits cover both in-flight requests and buffered words, so the FIFO never overflows.
  assign in_use         = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid = !rstf && !redirect_valid && (in_use < {1'b0, DEPTH_C});
  assign imem_addr      = pc;
  assign issue          = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && !redirect_valid && (drop == '0);
  assign rsp_drop       = imem_rsp_valid && !redirect_valid && (drop != '0);
  assign pop            = i_instr_valid && i_instr_ready && !redirect_valid;

  assign i_instr_valid  = (count != '0);
  assign i_instr        = i_instr_valid ? fifo_instr[rd_ptr] : '0;
  assign oPC            = i_instr_valid ? fifo_pc[rd_ptr]    : '0;

  always_ff @(posedge clk) begin
    if (rstf) begin
      pc          <= RESET_PC & 32'hFFFF_FFFC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        // Everything still in flight belongs to the old path; a response landing now is dropped too.
        pc     <= redirect_pc & 32'hFFFF_FFFC;
        drop   <= outstanding - CW'(imem_rsp_valid);
        count  <= '0;
        rd_ptr <= wr_ptr;
        pcq_rd <= pcq_wr;
      end else begin
        if (issue) begin
          pc     <= pc + 32'd4;
          pcq_wr <= pcq_wr + AW'(1);
        end
        if (rsp_drop) drop <= drop - CW'(1);
        if (rsp_keep) begin
          wr_ptr <= wr_ptr + AW'(1);
          pcq_rd <= pcq_rd + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(rsp_keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pcq[pcq_wr] <= pc;
    if (rsp_keep) begin
      fifo_instr[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]    <= pcq[pcq_rd];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstf) begin
      assert (!(rsp_keep && !pop && count == DEPTH_C));
      assert (!(imem_rsp_valid && outstanding == '0));
      assert (!(rsp_drop && drop == '0));
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based memory/stream model.
module tb_instruction_fetch;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rstf;
  logic [31:0] imem_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] i_instr;
  logic        i_instr_valid;
  logic        i_instr_ready;
  logic [31:0] oPC;

  instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstf(rstf),
    .imem_addr(imem_addr), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_rsp_data(imem_rsp_data), .imem_rsp_valid(imem_rsp_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .i_instr(i_instr), .i_instr_valid(i_instr_valid), .i_instr_ready(i_instr_ready),
    .oPC(oPC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic        ins_rdy;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_opc;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Reference model: in-flight requests, buffered word count, expected PC streams.
  req_t        q[$];
  int          buffered  = 0;
  int          epoch     = 0;
  int          cyc       = 0;
  int          lat       = 1;
  int          delivered = 0;
  logic [31:0] exp_pc    = RESET_PC;
  logic [31:0] exp_fetch = RESET_PC;
  logic        post_reset = 1'b0;
  logic        wait_first = 1'b0;
  logic [31:0] first_pc  = 32'hDEAD_BEEF;
  logic        saw_wrap  = 1'b0;
  logic [31:0] last_acc  = 32'h0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return ~a ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic rst, input logic redir, input logic [31:0] rpc,
                      input logic rq_rdy, input logic in_rdy);
    logic rsp;
    logic exp_rv;
    logic exp_iv;
    req_t h;
    @(posedge clk);
    #1;
    rsp = !rst && (q.size() != 0) && (q[0].due <= cyc);
    rstf           = rst;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = rq_rdy;
    i_instr_ready  = in_rdy;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? word_of(q[0].addr) : $urandom;
    #1;
    exp_rv = !redir && ((q.size() + buffered) < DEPTH);
    exp_iv = (buffered != 0);
    if (!rst) begin
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
      if (exp_rv) chk("imem_addr", imem_addr, exp_fetch);
      chk("instr_valid", {31'b0, i_instr_valid}, {31'b0, exp_iv});
      if (exp_iv) begin
        chk("opc", oPC, exp_pc);
        chk("instr", i_instr, word_of(exp_pc));
      end
      if (post_reset) begin
        chk("reset_instr", i_instr, 32'h0);
        chk("reset_opc", oPC, 32'h0);
      end
      if (imem_req_valid && rq_rdy) begin
        if (imem_addr == 32'h0 && last_acc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
        last_acc = imem_addr;
      end
    end
    if (rst) begin
      q.delete();
      buffered   = 0;
      epoch++;
      exp_pc     = RESET_PC;
      exp_fetch  = RESET_PC;
      post_reset = 1'b1;
    end else begin
      post_reset = 1'b0;
      if (rsp) begin
        h = q.pop_front();
        if (!redir && h.epoch == epoch) buffered++;
      end
      if (redir) begin
        epoch++;
        buffered  = 0;
        exp_pc    = rpc & 32'hFFFF_FFFC;
        exp_fetch = rpc & 32'hFFFF_FFFC;
      end else begin
        if (exp_rv && rq_rdy) begin
          q.push_back('{addr: exp_fetch, epoch: epoch, due: cyc + lat});
          exp_fetch += 32'd4;
        end
        if (exp_iv && in_rdy) begin
          if (wait_first) begin
            first_pc   = oPC;
            wait_first = 1'b0;
          end
          buffered--;
          exp_pc += 32'd4;
          delivered++;
        end
      end
    end
    cyc++;
  endtask

  vec_t tbl[11];
  int   d0;

  initial begin
    rstf = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; i_instr_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    // 1-cycle memory, always ready; decode stalls for four cycles in the middle.
    tbl[0]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
    tbl[3]  = '{1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
    tbl[4]  = '{1'b1, 1'b1, 32'h110, 1'b1, 32'h108};
    tbl[5]  = '{1'b0, 1'b1, 32'h114, 1'b1, 32'h10C};
    tbl[6]  = '{1'b0, 1'b1, 32'h118, 1'b1, 32'h10C};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10C};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10C};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10C};
    tbl[10] = '{1'b1, 1'b1, 32'h11C, 1'b1, 32'h110};

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

    lat = 1;
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, tbl[i].ins_rdy);
      chk("tbl_req_valid", {31'b0, imem_req_valid}, {31'b0, tbl[i].exp_rv});
      if (tbl[i].exp_rv) chk("tbl_addr", imem_addr, tbl[i].exp_addr);
      chk("tbl_instr_valid", {31'b0, i_instr_valid}, {31'b0, tbl[i].exp_iv});
      if (tbl[i].exp_iv) chk("tbl_opc", oPC, tbl[i].exp_opc);
    end

    // Redirect to an unaligned target while several slow fetches are in flight.
    lat = 3;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0203, 1'b1, 1'b1);
    wait_first = 1'b1;
    first_pc   = 32'hDEAD_BEEF;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("redirect_first_pc", first_pc, 32'h200);

    // Redirects landing on response cycles, with request-side stalls.
    lat = 1;
    for (int i = 0; i < 60; i++)
      step(1'b0, (i % 7 == 3), $urandom, 1'($urandom % 2), 1'($urandom % 2));

    // PC wrap past the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFF6, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("pc_wrap_seen", {31'b0, saw_wrap}, 32'h1);

    // Fill the FIFO, then reset mid-stream.
    for (int i = 0; i < 20; i++) begin
      if (buffered == DEPTH) break;
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("fifo_full_valid", {31'b0, i_instr_valid}, 32'h1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("rst_instr_valid", {31'b0, i_instr_valid}, 32'h0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("rst_first_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("rst_first_fetch", imem_addr, RESET_PC);

    // Randomized traffic against the model.
    d0 = delivered;
    for (int i = 0; i < 2500; i++) begin
      lat = $urandom_range(1, 3);
      step(($urandom % 200) == 0, ($urandom % 30) == 0, $urandom,
           ($urandom % 10) < 7, ($urandom % 10) < 7);
    end
    chk("random_progress", {31'b0, (delivered - d0) > 200}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
